id_pipe: RTL

- Next-generation decode stage for the OpenMIPS-style pipeline.
- Decodes a wider instruction subset than the ORI-only decoder: ORI/ANDI/XORI/LUI, SPECIAL AND/OR/XOR/NOR, shifts, and LW.
- Resolves operands with EX/MEM forwarding and detects load-use hazards.
- Holds the ID/EX pipeline register with valid/ready handshakes on both sides, between IF/ID and EX.

---
 rtl/id_pipe_if.sv | 35 +++
 rtl/id_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_if.sv
// Handshake and payload bundle between IF/ID, the decode stage and EX.
// The _i/_o suffixes are named from the decode stage's point of view.
interface id_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [31:0]         pc_i;
  logic [31:0]         inst_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [DATA_W-1:0]   reg1_o;
  logic [DATA_W-1:0]   reg2_o;
  logic [RADDR_W-1:0]  wd_o;
  logic                wreg_o;
  logic [31:0]         pc_o;
  logic                inst_invalid_o;

  modport slave (
    input  in_valid_i, pc_i, inst_i, out_ready_i,
    output in_ready_o, out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, pc_o, inst_invalid_o
  );

  modport master (
    output in_valid_i, pc_i, inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, pc_o, inst_invalid_o
  );
endinterface

// File: rtl/id_pipe.sv
// Decode stage: instruction decode, operand forwarding, load-use stall detection
// and the ID/EX pipeline register with valid/ready handshakes on both sides.
module id_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  id_pipe_if.slave           bus,
  output logic               reg1_read_o,
  output logic               reg2_read_o,
  output logic [RADDR_W-1:0] reg1_addr_o,
  output logic [RADDR_W-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0]  reg1_data_i,
  input  logic [DATA_W-1:0]  reg2_data_i,
  input  logic               ex_wreg_i,
  input  logic [RADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wreg_i,
  input  logic [RADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  output logic [CNT_W-1:0]   stall_cnt_o
);
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_LOAD  = 3'b111;

  localparam logic [RADDR_W-1:0] ZERO_ADDR = {RADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]         op_s, funct_s;
  logic [4:0]         sa_s;
  logic               re1_d, re2_d, wreg_d, invalid_d;
  logic [RADDR_W-1:0] wd_d;
  logic [7:0]         aluop_d;
  logic [2:0]         alusel_d;
  logic [DATA_W-1:0]  imm_d, reg1_d, reg2_d;
  logic               load_use_s, advance_s, take_s;

  logic               out_valid_q, wreg_q, invalid_q;
  logic [7:0]         aluop_q;
  logic [2:0]         alusel_q;
  logic [DATA_W-1:0]  reg1_q, reg2_q;
  logic [RADDR_W-1:0] wd_q;
  logic [31:0]        pc_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  // Loads still in EX have no result yet, so they never forward.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic               re,
    input logic [RADDR_W-1:0] addr,
    input logic [DATA_W-1:0]  rdata,
    input logic [DATA_W-1:0]  imm,
    input logic               ex_wreg,
    input logic               ex_load,
    input logic [RADDR_W-1:0] ex_wd,
    input logic [DATA_W-1:0]  ex_wdata,
    input logic               mem_wreg,
    input logic [RADDR_W-1:0] mem_wd,
    input logic [DATA_W-1:0]  mem_wdata
  );
    if (!re) begin
      return imm;
    end else if (addr == ZERO_ADDR) begin
      return {DATA_W{1'b0}};
    end else if (ex_wreg && (ex_wd == addr) && !ex_load) begin
      return ex_wdata;
    end else if (mem_wreg && (mem_wd == addr)) begin
      return mem_wdata;
    end else begin
      return rdata;
    end
  endfunction

  assign op_s    = bus.inst_i[31:26];
  assign sa_s    = bus.inst_i[10:6];
  assign funct_s = bus.inst_i[5:0];

  always_comb begin
    re1_d     = 1'b0;
    re2_d     = 1'b0;
    wd_d      = bus.inst_i[15:11];
    wreg_d    = 1'b0;
    aluop_d   = EXE_NOP_OP;
    alusel_d  = EXE_RES_NOP;
    imm_d     = {DATA_W{1'b0}};
    invalid_d = 1'b1;
    if (bus.inst_i == 32'h0000_0000) begin
      invalid_d = 1'b0;
    end else begin
      case (op_s)
        6'b001101, 6'b001100, 6'b001110: begin
          re1_d     = 1'b1;
          imm_d     = {{(DATA_W-16){1'b0}}, bus.inst_i[15:0]};
          wd_d      = bus.inst_i[20:16];
          wreg_d    = 1'b1;
          alusel_d  = EXE_RES_LOGIC;
          invalid_d = 1'b0;
          case (op_s)
            6'b001100: aluop_d = EXE_AND_OP;
            6'b001110: aluop_d = EXE_XOR_OP;
            default:   aluop_d = EXE_OR_OP;
          endcase
        end
        6'b001111: begin
          re1_d     = 1'b1;
          imm_d     = {bus.inst_i[15:0], {(DATA_W-16){1'b0}}};
          wd_d      = bus.inst_i[20:16];
          wreg_d    = 1'b1;
          aluop_d   = EXE_OR_OP;
          alusel_d  = EXE_RES_LOGIC;
          invalid_d = 1'b0;
        end
        6'b100011: begin
          re1_d     = 1'b1;
          imm_d     = {{(DATA_W-16){bus.inst_i[15]}}, bus.inst_i[15:0]};
          wd_d      = bus.inst_i[20:16];
          wreg_d    = 1'b1;
          aluop_d   = EXE_LW_OP;
          alusel_d  = EXE_RES_LOAD;
          invalid_d = 1'b0;
        end
        6'b000000: begin
          case (funct_s)
            6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
              if (sa_s == 5'd0) begin
                re1_d     = 1'b1;
                re2_d     = 1'b1;
                wreg_d    = 1'b1;
                alusel_d  = EXE_RES_LOGIC;
                invalid_d = 1'b0;
                aluop_d   = {2'b00, funct_s};
              end else begin
                invalid_d = 1'b1;
              end
            end
            6'b000000, 6'b000010, 6'b000011: begin
              if (bus.inst_i[25:21] == 5'd0) begin
                re2_d     = 1'b1;
                imm_d     = {{(DATA_W-5){1'b0}}, sa_s};
                wreg_d    = 1'b1;
                alusel_d  = EXE_RES_SHIFT;
                invalid_d = 1'b0;
                aluop_d   = (funct_s == 6'b000000) ? EXE_SLL_OP :
                            (funct_s == 6'b000010) ? EXE_SRL_OP : EXE_SRA_OP;
              end else begin
                invalid_d = 1'b1;
              end
            end
            6'b000100, 6'b000110, 6'b000111: begin
              re1_d     = 1'b1;
              re2_d     = 1'b1;
              wreg_d    = 1'b1;
              alusel_d  = EXE_RES_SHIFT;
              invalid_d = 1'b0;
              aluop_d   = (funct_s == 6'b000100) ? EXE_SLL_OP :
                          (funct_s == 6'b000110) ? EXE_SRL_OP : EXE_SRA_OP;
            end
            default: invalid_d = 1'b1;
          endcase
        end
        default: invalid_d = 1'b1;
      endcase
    end
  end

  assign reg1_read_o = re1_d;
  assign reg2_read_o = re2_d;
  assign reg1_addr_o = bus.inst_i[25:21];
  assign reg2_addr_o = bus.inst_i[20:16];

  assign reg1_d = pick_operand(re1_d, reg1_addr_o, reg1_data_i, imm_d, ex_wreg_i, ex_is_load_i,
                               ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign reg2_d = pick_operand(re2_d, reg2_addr_o, reg2_data_i, imm_d, ex_wreg_i, ex_is_load_i,
                               ex_wd_i, ex_wdata_i, mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign load_use_s = bus.in_valid_i && ex_wreg_i && ex_is_load_i && (ex_wd_i != ZERO_ADDR) &&
                      ((re1_d && (ex_wd_i == reg1_addr_o)) || (re2_d && (ex_wd_i == reg2_addr_o)));
  assign advance_s  = !out_valid_q || bus.out_ready_i;
  assign take_s     = bus.in_valid_i && !load_use_s && !flush_i;
  assign bus.in_ready_o = advance_s && !load_use_s && !flush_i;

  // ID/EX register and stall counter; flush beats backpressure, bubbles carry no write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wreg_q      <= 1'b0;
      invalid_q   <= 1'b0;
      aluop_q     <= EXE_NOP_OP;
      alusel_q    <= EXE_RES_NOP;
      reg1_q      <= {DATA_W{1'b0}};
      reg2_q      <= {DATA_W{1'b0}};
      wd_q        <= ZERO_ADDR;
      pc_q        <= 32'h0000_0000;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (load_use_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (flush_i) begin
        out_valid_q <= 1'b0;
        wreg_q      <= 1'b0;
        aluop_q     <= EXE_NOP_OP;
      end else if (advance_s) begin
        out_valid_q <= take_s;
        if (take_s) begin
          wreg_q    <= wreg_d;
          invalid_q <= invalid_d;
          aluop_q   <= aluop_d;
          alusel_q  <= alusel_d;
          reg1_q    <= reg1_d;
          reg2_q    <= reg2_d;
          wd_q      <= wd_d;
          pc_q      <= bus.pc_i;
        end else begin
          wreg_q    <= 1'b0;
          aluop_q   <= EXE_NOP_OP;
        end
      end
    end
  end

  assign bus.out_valid_o    = out_valid_q;
  assign bus.wreg_o         = wreg_q;
  assign bus.inst_invalid_o = invalid_q;
  assign bus.aluop_o        = aluop_q;
  assign bus.alusel_o       = alusel_q;
  assign bus.reg1_o         = reg1_q;
  assign bus.reg2_o         = reg2_q;
  assign bus.wd_o           = wd_q;
  assign bus.pc_o           = pc_q;
  assign stall_cnt_o        = stall_cnt_q;
endmodule
